data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, word width; multiple of 8, at least 16.
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra access cycles, range 0..15.
REQ-004 SHALL have parameter INIT_CLEAR, default 1; 1 = zero-fill the array after reset.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset; one clock, synchronous, active-low.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, request accepted when both valid and ready are high at an edge.
REQ-009 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port req_byte, input, 1, 1 = byte access, 0 = full-word access.
REQ-011 SHALL have port req_signed, input, 1, sign-extend byte loads.
REQ-012 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-013 SHALL have port req_wdata, input, DATA_W, store data; byte stores use bits [7:0].
REQ-014 SHALL have port rsp_valid, output, 1, one-cycle response strobe; no backpressure.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1, misaligned access, qualified by rsp_valid.
REQ-017 SHALL have port init_done, output, 1, high once the array is usable.

Function
REQ-018 SHALL implement FSM states INIT, IDLE, WAIT, RESP.
REQ-019 SHALL step INIT through all DEPTH = 2^ADDR_W/(DATA_W/8) words, one zero write per cycle, then enter IDLE; INIT_CLEAR=0 skips INIT.
REQ-020 SHALL drive req_ready high only in IDLE with init_done high.
REQ-021 SHALL, on acceptance, enter WAIT when WAIT_STATES>0, otherwise enter RESP; WAIT lasts exactly WAIT_STATES cycles, counted by a down-counter.
REQ-022 SHALL assert rsp_valid for exactly one cycle, WAIT_STATES+1 clocks after the accepting edge, then return to IDLE; maximum throughput is one request per WAIT_STATES+2 cycles.
REQ-023 SHALL store little-endian: byte at addr holds bits [7:0], byte at addr+k holds bits [8k+7:8k].
REQ-024 SHALL commit stores at the accepting edge using per-byte lane enables; byte stores write only one lane.
REQ-025 SHALL capture load data at acceptance, so a load issued after a store to the same address returns the new data.
REQ-026 SHALL return byte loads zero-extended, or sign-extended from bit 7 when req_signed=1.
REQ-027 SHALL treat a word access with req_addr not a multiple of DATA_W/8 as an error: rsp_err=1, rsp_rdata=0, no array write.
REQ-028 SHALL ignore req_* inputs while req_ready is low.

Reset
REQ-029 SHALL, when reset_n is low at an edge, set state to INIT (IDLE if INIT_CLEAR=0), and clear req_ready, rsp_valid, rsp_err, rsp_rdata, init_done, the wait counter and the init pointer.
REQ-030 SHALL drop an in-flight transaction when reset occurs mid-operation: no rsp_valid, and the sweep restarts from word 0.

Structure
REQ-031 SHALL place the state enum and size/lane-count helper constants in shared package dmem_pkg.
REQ-032 SHALL isolate storage in sub-module dmem_array: DEPTH x DATA_W words with per-byte write enables and a combinational read.

Verification (ADDR_W=8, DATA_W=16, WAIT_STATES=1)
REQ-033 SHALL test reset release: init_done rises 128 cycles later; word load of 0x10 returns 0x0000.
REQ-034 SHALL test store 0x1234 at 0x04, then loads: byte 0x04 -> 0x0034, byte 0x05 -> 0x0012, word -> 0x1234; each rsp_valid appears 2 clocks after acceptance.
REQ-035 SHALL test byte store 0xAB at 0x07: signed byte load -> 0xFFAB, unsigned -> 0x00AB, word load 0x06 -> 0xAB00.
REQ-036 SHALL test word store 0xBEEF at 0x03: rsp_err=1; word loads at 0x02 and 0x04 still return prior values.
REQ-037 SHALL test req_valid held high for 3 requests: acceptances spaced exactly 3 cycles apart; req_ready low in WAIT and RESP.
REQ-038 SHALL test reset asserted in WAIT: no rsp_valid; req_ready stays low until the 128-cycle re-init completes.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data memory controller.
// The controller and its storage array derive their geometry from these helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int depth_of(input int addr_w, input int data_w);
        return (1 << addr_w) / (data_w / 8);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with one write enable per byte lane.
// Reads are combinational so load data is available in the accepting cycle.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                                        clk,
    input  logic [lanes_of(DATA_W)-1:0]                 wr_be,
    input  logic [ptr_width(depth_of(ADDR_W, DATA_W))-1:0] wr_addr,
    input  logic [DATA_W-1:0]                           wr_data,
    input  logic [ptr_width(depth_of(ADDR_W, DATA_W))-1:0] rd_addr,
    output logic [DATA_W-1:0]                           rd_data
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int DEPTH = depth_of(ADDR_W, DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller: byte/word loads and stores with fixed
// wait states, misalignment errors and an optional zero-fill sweep after reset.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int INIT_CLEAR  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int DEPTH = depth_of(ADDR_W, DATA_W);
    localparam int PTR_W = ptr_width(DEPTH);

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      init_ptr_q, init_ptr_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  pend_err_q, pend_err_d;
    logic [DATA_W-1:0]     pend_rdata_q, pend_rdata_d;

    logic                  accept;
    logic                  misaligned;
    logic [ADDR_W-1:0]     lane;
    logic [7:0]            byte_val;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     load_val;
    logic [PTR_W-1:0]      rd_addr;
    logic [PTR_W-1:0]      wr_addr;
    logic [LANES-1:0]      wr_be;
    logic [DATA_W-1:0]     wr_data;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_be   (wr_be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // Datapath: decode the request, format load data and drive the array write port.
    always_comb begin
        accept     = reset_n && req_valid && req_ready_q;
        lane       = req_addr % ADDR_W'(LANES);
        misaligned = !req_byte && (lane != '0);
        rd_addr    = PTR_W'(req_addr / ADDR_W'(LANES));

        byte_val = rd_word[7:0];
        for (int i = 0; i < LANES; i++) begin
            if (lane == ADDR_W'(i)) begin
                byte_val = rd_word[i*8 +: 8];
            end
        end

        if (misaligned) begin
            load_val = '0;
        end else if (req_byte) begin
            load_val = {{(DATA_W-8){req_signed & byte_val[7]}}, byte_val};
        end else begin
            load_val = rd_word;
        end

        wr_be   = '0;
        wr_addr = rd_addr;
        wr_data = req_wdata;
        if (state_q == ST_INIT && reset_n) begin
            wr_be   = '1;
            wr_addr = init_ptr_q;
            wr_data = '0;
        end else if (accept && req_write && !misaligned) begin
            if (req_byte) begin
                wr_data = {LANES{req_wdata[7:0]}};
                for (int i = 0; i < LANES; i++) begin
                    wr_be[i] = (lane == ADDR_W'(i));
                end
            end else begin
                wr_be = '1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        wait_cnt_d   = wait_cnt_q;
        init_done_d  = init_done_q;
        pend_err_d   = pend_err_q;
        pend_rdata_d = pend_rdata_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;

        case (state_q)
            ST_INIT: begin
                if (init_ptr_q == PTR_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    init_ptr_d  = '0;
                    init_done_d = 1'b1;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (accept) begin
                    pend_err_d   = misaligned;
                    pend_rdata_d = req_write ? '0 : load_val;
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = pend_err_q;
                rsp_rdata_d = pend_rdata_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE) && init_done_d;
    end

    // The response strobe is registered on leaving RESP, which puts it
    // WAIT_STATES+1 edges after acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
            init_ptr_q   <= '0;
            wait_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            pend_err_q   <= 1'b0;
            pend_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            init_done_q  <= init_done_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            pend_err_q   <= pend_err_d;
            pend_rdata_q <= pend_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with 256-byte space, 16-bit words and one wait state.
// Expected values are hand-computed from little-endian byte layout and the response timing.
module tb_data_memory_ctrl;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int WAIT_STATES = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_STATES (WAIT_STATES),
        .INIT_CLEAR  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done)
    );

    typedef struct {
        logic        write;
        logic        is_byte;
        logic        sgn;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts rising edges until req_ready is seen high; called at a negedge.
    task automatic waitReady(output int n, output bit sawRsp);
        n = 0;
        sawRsp = 1'b0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (rsp_valid) sawRsp = 1'b1;
        end
    endtask

    // Issues one request and returns the response; called and returns at a negedge.
    task automatic applyStimulus(input logic wr, input logic bt, input logic sg,
                                 input logic [7:0] addr, input logic [15:0] wd,
                                 output logic [15:0] rdata, output logic err, output int lat);
        int waitCnt = 0;
        req_write  = wr;
        req_byte   = bt;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (!req_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            rdata = '0;
            err = 1'b0;
            lat = 99;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        checkOutput("rsp_valid one cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          n;
        bit          sawRsp;
        int          acc[3];
        int          nAcc;
        logic        rdyTrace[32];
        logic        rspTrace[32];

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h04, 16'h1234, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h04, 16'h0000, 16'h0034, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 16'h0012, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h04, 16'h0000, 16'h1234, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h07, 16'h55AB, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h07, 16'h0000, 16'hFFAB, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h07, 16'h0000, 16'h00AB, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h06, 16'h0000, 16'hAB00, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h02, 16'h5678, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h03, 16'hBEEF, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h02, 16'h0000, 16'h5678, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h04, 16'h0000, 16'h1234, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h03, 16'h0000, 16'h0000, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h05, 16'hFF00, 16'h0000, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h04, 16'h0000, 16'h0034, 1'b0};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_byte   = 1'b0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset state and the zero-fill sweep.
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset init_done", {31'd0, init_done}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        reset_n = 1'b1;
        waitReady(n, sawRsp);
        checkOutput("init cycles", n, 128);
        checkOutput("init_done with ready", {31'd0, init_done}, 32'd1);
        checkOutput("no rsp during init", {31'd0, sawRsp}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 16'h0, rdata, err, lat);
        checkOutput("cleared word 0x10", {16'd0, rdata}, 32'h0);
        checkOutput("cleared word 0x10 latency", lat, 2);

        // Table-driven loads and stores.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].write, vecs[i].is_byte, vecs[i].sgn, vecs[i].addr,
                          vecs[i].wdata, rdata, err, lat);
            checkOutput($sformatf("vec%0d rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
            checkOutput($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            checkOutput($sformatf("vec%0d latency", i), lat, 2);
        end

        // req_valid held high across three back-to-back word loads of 0x04.
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 8'h04;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        nAcc = 0;
        for (int c = 0; c < 32; c++) begin
            if (nAcc == 3) req_valid = 1'b0;
            rdyTrace[c] = req_ready;
            rspTrace[c] = rsp_valid;
            if (req_valid && req_ready && nAcc < 3) begin
                acc[nAcc] = c;
                nAcc++;
            end
            @(negedge clk);
        end
        checkOutput("b2b acceptances", nAcc, 3);
        if (nAcc == 3) begin
            checkOutput("b2b spacing 0-1", acc[1] - acc[0], 3);
            checkOutput("b2b spacing 1-2", acc[2] - acc[1], 3);
            checkOutput("b2b ready in WAIT", {31'd0, rdyTrace[acc[0] + 1]}, 32'd0);
            checkOutput("b2b ready in RESP", {31'd0, rdyTrace[acc[0] + 2]}, 32'd0);
            checkOutput("b2b rsp before", {31'd0, rspTrace[acc[0] + 2]}, 32'd0);
            checkOutput("b2b rsp strobe", {31'd0, rspTrace[acc[0] + 3]}, 32'd1);
            checkOutput("b2b last rsp strobe", {31'd0, rspTrace[acc[2] + 3]}, 32'd1);
        end

        // Reset while a load is waiting: response dropped and array swept again.
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 8'h04;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mid-op reset req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("mid-op reset init_done", {31'd0, init_done}, 32'd0);
        checkOutput("mid-op reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        reset_n = 1'b1;
        waitReady(n, sawRsp);
        checkOutput("re-init cycles", n, 128);
        checkOutput("dropped rsp", {31'd0, sawRsp}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h04, 16'h0, rdata, err, lat);
        checkOutput("swept word 0x04", {16'd0, rdata}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
